// File: rtl/cva6_spi_master_rx.sv
// SPI master receive deserializer: samples MISO (standard) or four data lines (quad)
// on rx_edge, packs MSB-first into 32-bit words and hands them to the RX FIFO.
module cva6_spi_master_rx #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned RST_TRGT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             rx_edge,
   output logic             rx_done,
   input  logic             sdi0,
   input  logic             sdi1,
   input  logic             sdi2,
   input  logic             sdi3,
   input  logic             en_quad_in,
   input  logic [CNT_W-1:0] counter_in,
   input  logic             counter_in_upd,
   output logic [31:0]      data,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             clk_en_o
);

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      RECEIVE        = 2'd1,
      WAIT_FIFO      = 2'd2,
      WAIT_FIFO_DONE = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] counter, counter_next, counter_trgt;
   logic [31:0]      sh, sh_next, shifted, data_next;
   logic             data_valid_next;
   logic             word_end, last;

   // Shift candidate, word boundary and end-of-transfer detection
   always_comb begin
      if (en_quad_in) begin
         shifted  = {sh[27:0], sdi3, sdi2, sdi1, sdi0};
         word_end = rx_edge && (counter[2:0] == 3'd7);
      end else begin
         shifted  = {sh[30:0], sdi1};
         word_end = rx_edge && (counter[4:0] == 5'd31);
      end
      last = rx_edge && (counter == (counter_trgt - CNT_W'(1)));
   end

   // Next-state, datapath updates and clock-enable/done outputs
   always_comb begin
      state_next      = state;
      counter_next    = counter;
      sh_next         = sh;
      data_next       = data;
      data_valid_next = data_valid && !data_ready;
      clk_en_o        = 1'b0;
      rx_done         = 1'b0;
      case (state)
         IDLE: begin
            if (en && (counter_trgt != '0)) begin
               sh_next      = 32'd0;
               counter_next = '0;
               state_next   = RECEIVE;
            end else begin
               state_next = IDLE;
            end
         end
         RECEIVE: begin
            clk_en_o = 1'b1;
            rx_done  = last;
            if (rx_edge) begin
               counter_next = counter + CNT_W'(1);
               sh_next      = shifted;
               if (word_end || last) begin
                  if (!data_valid || data_ready) begin
                     data_next       = shifted;
                     data_valid_next = 1'b1;
                     sh_next         = 32'd0;
                     if (last) begin
                        counter_next = '0;
                        state_next   = IDLE;
                     end else begin
                        state_next = RECEIVE;
                     end
                  end else begin
                     // Consumer still holds the previous word: stop the SPI clock now
                     clk_en_o   = 1'b0;
                     state_next = last ? WAIT_FIFO_DONE : WAIT_FIFO;
                  end
               end else begin
                  state_next = RECEIVE;
               end
            end else begin
               state_next = RECEIVE;
            end
         end
         WAIT_FIFO, WAIT_FIFO_DONE: begin
            if (data_ready) begin
               data_next       = sh;
               data_valid_next = 1'b1;
               sh_next         = 32'd0;
               if (state == WAIT_FIFO_DONE) begin
                  counter_next = '0;
                  state_next   = IDLE;
               end else begin
                  state_next = RECEIVE;
               end
            end else begin
               state_next = state;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         sh         <= 32'd0;
         data       <= 32'd0;
         data_valid <= 1'b0;
      end else begin
         state      <= state_next;
         counter    <= counter_next;
         sh         <= sh_next;
         data       <= data_next;
         data_valid <= data_valid_next;
      end
   end

   // Transfer target; quad mode counts nibbles rather than bits
   always_ff @(posedge clk) begin
      if (rst) begin
         counter_trgt <= CNT_W'(RST_TRGT);
      end else if (counter_in_upd) begin
         counter_trgt <= en_quad_in ? (counter_in >> 2) : counter_in;
      end else begin
         counter_trgt <= counter_trgt;
      end
   end

endmodule

// File: tb/tb_cva6_spi_master_rx.sv
// Directed self-checking bench for cva6_spi_master_rx.
module tb_cva6_spi_master_rx;

   logic        clk = 1'b0;
   logic        rst, en, rx_edge, rx_done;
   logic        sdi0, sdi1, sdi2, sdi3, en_quad_in;
   logic [15:0] counter_in;
   logic        counter_in_upd;
   logic [31:0] data;
   logic        data_valid, data_ready, clk_en_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cva6_spi_master_rx #(.CNT_W(16), .RST_TRGT(8)) dut (
      .clk(clk), .rst(rst), .en(en), .rx_edge(rx_edge), .rx_done(rx_done),
      .sdi0(sdi0), .sdi1(sdi1), .sdi2(sdi2), .sdi3(sdi3),
      .en_quad_in(en_quad_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
      .data(data), .data_valid(data_valid), .data_ready(data_ready), .clk_en_o(clk_en_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample strobe; returns rx_done / clk_en_o as seen just before the edge
   task automatic strobe(input logic [3:0] lines, output logic done_s, output logic ce_s);
      {sdi3, sdi2, sdi1, sdi0} = lines;
      rx_edge = 1'b1;
      #1;
      done_s = rx_done;
      ce_s   = clk_en_o;
      @(posedge clk);
      #1;
      rx_edge = 1'b0;
   endtask

   task automatic start(input logic [15:0] len, input logic quad);
      en_quad_in     = quad;
      counter_in     = len;
      counter_in_upd = 1'b1;
      tick();
      counter_in_upd = 1'b0;
      en = 1'b1;
      tick();
      en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] w0, w1;
      logic        d, ce;
      int          early;

      rst = 1'b1; en = 1'b0; rx_edge = 1'b0; en_quad_in = 1'b0;
      {sdi3, sdi2, sdi1, sdi0} = 4'h0;
      counter_in = 16'd0; counter_in_upd = 1'b0; data_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_val("rst_valid", {31'd0, data_valid}, 32'd0);
      check_val("rst_data", data, 32'd0);
      check_val("rst_clken", {31'd0, clk_en_o}, 32'd0);
      check_val("rst_done", {31'd0, rx_done}, 32'd0);

      // Standard 32-bit word
      w0 = 32'hA5A51234; early = 0;
      start(16'd32, 1'b0);
      check_val("std_clken_run", {31'd0, clk_en_o}, 32'd1);
      for (int i = 31; i >= 0; i--) begin
         strobe({2'b00, w0[i], 1'b0}, d, ce);
         if (i == 0) check_val("std_done_last", {31'd0, d}, 32'd1);
         else if (d) early++;
      end
      check_val("std_done_early", early, 32'd0);
      check_val("std_valid", {31'd0, data_valid}, 32'd1);
      check_val("std_data", data, 32'hA5A51234);
      check_val("std_clken_idle", {31'd0, clk_en_o}, 32'd0);
      tick();
      check_val("std_valid_clr", {31'd0, data_valid}, 32'd0);

      // Quad two-word read
      w0 = 32'hDEADBEEF; w1 = 32'h01234567; early = 0;
      start(16'd64, 1'b1);
      for (int k = 0; k < 16; k++) begin
         strobe(k < 8 ? w0[31-4*k -: 4] : w1[31-4*(k-8) -: 4], d, ce);
         if (k == 15) check_val("quad_done_last", {31'd0, d}, 32'd1);
         else if (d) early++;
         if (k == 7) begin
            check_val("quad_w0_valid", {31'd0, data_valid}, 32'd1);
            check_val("quad_w0", data, 32'hDEADBEEF);
         end
      end
      check_val("quad_done_early", early, 32'd0);
      check_val("quad_w1_valid", {31'd0, data_valid}, 32'd1);
      check_val("quad_w1", data, 32'h01234567);
      check_val("quad_clken_idle", {31'd0, clk_en_o}, 32'd0);
      tick();

      // Partial 12-bit word
      w0 = 32'h00000ABC;
      start(16'd12, 1'b0);
      for (int i = 11; i >= 0; i--) begin
         strobe({2'b00, w0[i], 1'b0}, d, ce);
         if (i == 0) check_val("part_done", {31'd0, d}, 32'd1);
      end
      check_val("part_data", data, 32'h00000ABC);
      tick();

      // Backpressure over a 64-bit read
      w0 = 32'h12345678; w1 = 32'h9ABCDEF0;
      data_ready = 1'b0;
      start(16'd64, 1'b0);
      for (int i = 0; i < 64; i++) begin
         strobe({2'b00, (i < 32) ? w0[31-i] : w1[63-i], 1'b0}, d, ce);
         if (i == 31) begin
            check_val("bp_w0_valid", {31'd0, data_valid}, 32'd1);
            check_val("bp_w0", data, 32'h12345678);
            check_val("bp_clken_mid", {31'd0, clk_en_o}, 32'd1);
         end
         if (i == 50) check_val("bp_w0_stable", data, 32'h12345678);
         if (i == 63) begin
            check_val("bp_clken_drop", {31'd0, ce}, 32'd0);
            check_val("bp_done", {31'd0, d}, 32'd1);
         end
      end
      check_val("bp_clken_wait", {31'd0, clk_en_o}, 32'd0);
      for (int i = 0; i < 3; i++) strobe(4'hF, d, ce);
      check_val("bp_w0_hold", data, 32'h12345678);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check_val("bp_w1_valid", {31'd0, data_valid}, 32'd1);
      check_val("bp_w1", data, 32'h9ABCDEF0);
      data_ready = 1'b1;
      tick();
      check_val("bp_valid_clr", {31'd0, data_valid}, 32'd0);
      check_val("bp_clken_idle", {31'd0, clk_en_o}, 32'd0);

      // Strobes in IDLE and en with zero target
      for (int i = 0; i < 3; i++) strobe(4'hF, d, ce);
      check_val("idle_edge_valid", {31'd0, data_valid}, 32'd0);
      start(16'd0, 1'b0);
      check_val("zero_trgt_idle", {31'd0, clk_en_o}, 32'd0);

      // Reset mid-transfer with a word pending
      w0 = 32'hCAFEF00D;
      data_ready = 1'b0;
      start(16'd40, 1'b0);
      for (int i = 0; i < 36; i++) strobe({2'b00, (i < 32) ? w0[31-i] : 1'b1, 1'b0}, d, ce);
      check_val("rst_pre_valid", {31'd0, data_valid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rstm_valid", {31'd0, data_valid}, 32'd0);
      check_val("rstm_data", data, 32'd0);
      check_val("rstm_clken", {31'd0, clk_en_o}, 32'd0);

      // Restored default target of 8 bits
      data_ready = 1'b1;
      en = 1'b1;
      tick();
      en = 1'b0;
      w0 = 32'h0000005A; early = 0;
      for (int i = 7; i >= 0; i--) begin
         strobe({2'b00, w0[i], 1'b0}, d, ce);
         if (i == 0) check_val("dflt_done", {31'd0, d}, 32'd1);
         else if (d) early++;
      end
      check_val("dflt_done_early", early, 32'd0);
      check_val("dflt_data", data, 32'h0000005A);
      check_val("dflt_clken_idle", {31'd0, clk_en_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
